// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode map and sequencer states.
// The operand-save stage imports the same W so both sides agree on nibble size.
package alu_pkg;

  localparam int W         = 4;
  localparam int MUL_STEPS = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_mul_step.sv
// One shift-add multiply iteration: adds A<<step into the accumulator when B[step] is set.
module alu_mul_step #(
  parameter int W  = alu_pkg::W,
  parameter int SW = $clog2(W)
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [SW-1:0]  step,
  output logic [2*W-1:0] acc_next
);

  logic [2*W-1:0] addend;

  always_comb begin
    addend   = (2*W)'(a) << step;
    acc_next = b[step] ? acc + addend : acc;
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential 4-bit ALU execution stage: single-cycle logic/arith ops plus an
// iterative shift-add multiply, returning result, flags and destination with a done pulse.
module alu_seq_core #(
  parameter int W         = alu_pkg::W,
  parameter int MUL_STEPS = alu_pkg::MUL_STEPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         dest,
  input  logic [W-1:0] data_inA,
  input  logic [W-1:0] data_inB,
  output logic [W-1:0] data_result,
  output logic [W-1:0] product_hi,
  output logic         carry,
  output logic         zero,
  output logic         busy,
  output logic         done,
  output logic         pos_save
);

  import alu_pkg::*;

  localparam int SW = $clog2(W);

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic           dest_q, dest_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [SW-1:0]  step_q, step_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   prod_hi_q, prod_hi_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           pos_save_q, pos_save_d;

  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   exec_res;
  logic           exec_carry;
  logic [W:0]     sum, diff, shl;

  alu_mul_step #(.W(W), .SW(SW)) u_mul_step (
    .acc      (acc_q),
    .a        (a_q),
    .b        (b_q),
    .step     (step_q),
    .acc_next (acc_nxt)
  );

  // Bit W of the widened shift holds the last bit shifted out (0 for a zero shift).
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    diff       = {1'b0, a_q} - {1'b0, b_q};
    shl        = {1'b0, a_q} << b_q[SW-1:0];
    exec_res   = a_q;
    exec_carry = 1'b0;
    case (op_q)
      OP_ADD: begin exec_res = sum[W-1:0];  exec_carry = sum[W];  end
      OP_SUB: begin exec_res = diff[W-1:0]; exec_carry = diff[W]; end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_NOT: exec_res = ~a_q;
      OP_SHL: begin exec_res = shl[W-1:0];  exec_carry = shl[W];  end
      default: begin exec_res = a_q; exec_carry = 1'b0; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dest_d     = dest_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    step_d     = step_q;
    result_d   = result_q;
    prod_hi_d  = prod_hi_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    pos_save_d = pos_save_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          dest_d  = dest;
          a_d     = data_inA;
          b_d     = data_inB;
          acc_d   = '0;
          step_d  = '0;
          state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d   = exec_res;
        prod_hi_d  = '0;
        carry_d    = exec_carry;
        zero_d     = (exec_res == '0);
        pos_save_d = dest_q;
        state_d    = ST_DONE;
      end
      ST_MUL: begin
        acc_d  = acc_nxt;
        step_d = step_q + SW'(1);
        if (step_q == SW'(MUL_STEPS - 1)) begin
          result_d   = acc_nxt[W-1:0];
          prod_hi_d  = acc_nxt[2*W-1:W];
          carry_d    = |acc_nxt[2*W-1:W];
          zero_d     = (acc_nxt[W-1:0] == '0);
          pos_save_d = dest_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      dest_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      result_q   <= '0;
      prod_hi_q  <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      pos_save_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      result_q   <= result_d;
      prod_hi_q  <= prod_hi_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      pos_save_q <= pos_save_d;
    end
  end

  assign data_result = result_q;
  assign product_hi  = prod_hi_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign pos_save    = pos_save_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- 4-bit sequential ALU execution stage.
- Consumes the A/B operand nibbles held by the operand-save stage and computes one operation per start request.
- Returns the 4-bit result with a one-cycle done pulse, plus the destination select (pos_save) that tells the save stage which register receives the result.
- Single-cycle logic ops; multiply is an iterative 4-step shift-add.

Parameters:
- W, 4, operand/result width; all arithmetic rules below are written for W=4.
- MUL_STEPS, 4, multiply iterations; must equal W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  3  operation code; latched with start.
- dest  in  1  result destination; latched with start; 1 = A, 0 = B.
- data_inA  in  W  operand A from the save stage.
- data_inB  in  W  operand B from the save stage.
- data_result  out  W  registered result; low nibble for MUL.
- product_hi  out  W  high nibble of the MUL product; 0 for other ops.
- carry  out  1  carry/borrow/overflow flag.
- zero  out  1  data_result == 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result, flags and pos_save are valid.
- pos_save  out  1  registered copy of the latched dest.

Behaviour:
- Reset is asynchronous, active-low:
  - All outputs go to 0, state goes to IDLE, internal operand/accumulator/counter registers clear.
  - Reset mid-operation aborts it; no done is produced.
- Opcodes:
  - 000 ADD: {carry, result} = A+B.
  - 001 SUB: result = A-B mod 16; carry = borrow (A<B).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 NOT A: carry = 0.
  - 110 MUL: 8-bit product; result = product[3:0], product_hi = product[7:4], carry = (product_hi != 0).
  - 111 SHL: A << B[1:0]; carry = last bit shifted out; shift 0 gives carry = 0.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - start=1 at an edge latches op, dest, A and B, then goes to MUL if op=110, otherwise to EXEC.
  - Operand inputs are don't-care after the latch edge.
- EXEC (single-cycle ops):
  - On the next edge, register data_result, product_hi=0, carry, zero and pos_save.
  - Go to DONE.
- MUL (iterative multiply):
  - Each edge: if B[step] is set, add A<<step into the 8-bit accumulator; increment step.
  - After step 3 (4 edges), register the outputs as above and go to DONE.
- DONE:
  - done=1 for exactly this one cycle; next edge returns to IDLE.
  - start is ignored in DONE; back-to-back ops need start held or re-asserted in IDLE.
- Latency from the start-sampling edge to done high:
  - 2 edges for single-cycle ops.
  - 5 edges for MUL.
- busy:
  - Rises the cycle after start is accepted.
  - Falls in the same cycle done falls.
  - start while busy is ignored.
- Output holding:
  - data_result, product_hi, carry, zero and pos_save hold their values until the next DONE entry.
  - They never change mid-operation.
  - This lets the save stage write on done without any extra handshake.
- zero is computed on data_result only; a MUL product of 0x10 gives zero=1 and carry=1.
- Unknown or X op: the implementation is free, but the FSM must still reach DONE (no lockup).

Decomposition:
- Shared package (alu_pkg): W, opcode localparams (OP_ADD..OP_SHL), and state encodings (ST_IDLE, ST_EXEC, ST_MUL, ST_DONE).
- The save stage imports the same W.
- One natural sub-module: alu_mul_step, the combinational single iteration (acc, A, B, step -> next acc).
- The opcode mux and FSM stay in alu_seq_core.

Test Plan:
- ADD, A=9, B=8, dest=1, start at one edge -> 2 edges later: done=1 for one cycle, data_result=1, carry=1, zero=0, pos_save=1; busy high for 2 cycles.
- SUB, A=3, B=5, dest=0 -> data_result=0xE, carry=1, pos_save=0. SUB with A=5, B=5 -> result=0, zero=1, carry=0.
- MUL, A=0xF, B=0xF -> done exactly 5 edges after start, data_result=1, product_hi=0xE, carry=1. MUL with A=3, B=2 -> result=6, product_hi=0, carry=0.
- SHL, A=0xB, B=2 -> result=0xC, carry=0. Also AND/OR/XOR/NOT with A=0xA, B=0x6 -> 0x2 / 0xE / 0xC / 0x5, carry=0.
- start pulsed while busy during a MUL, and operands changed after the latch edge -> ignored; the original MUL result is produced with a single done pulse.
- rst_n asserted asynchronously during MUL step 2 -> all outputs 0 immediately; no done pulse; a new ADD after release completes normally.
